// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like responder: transfer size encodings
// and the byte-enable / alignment helpers used by the write path.
package sram_like_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;
  localparam size_t SZ_ILL  = 2'b11;

  // Lane enables for a transfer of the given size starting at byte lane addr_lo.
  function automatic logic [3:0] be_of(input size_t size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << addr_lo;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // True for transfers that do not sit naturally inside one word, or use the reserved size.
  function automatic logic misaligned(input size_t size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
           (size == SZ_ILL);
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// In-order response FIFO. Every occupied entry counts down from RESP_LAT-1;
// the head becomes ready once its countdown reaches zero.
module resp_queue #(
  parameter int DEPTH    = 2,
  parameter int DATA_W   = 32,
  parameter int RESP_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DATA_W-1:0]            head_data,
  output logic                         head_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;
  localparam logic [3:0] LAT_LOAD = 4'(RESP_LAT - 1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [3:0]        cd_q   [DEPTH];
  logic [3:0]        cd_d   [DEPTH];
  logic [0:0]        st_q   [DEPTH];
  logic [0:0]        st_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign count      = count_q;
  assign head_data  = data_q[rd_ptr_q];
  assign head_ready = (st_q[rd_ptr_q] == ST_WAIT) && (cd_q[rd_ptr_q] == 4'd0);

  // Next-state: age all waiting entries, retire the head, append the new entry.
  always_comb begin
    data_d   = data_q;
    cd_d     = cd_q;
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((st_q[i] == ST_WAIT) && (cd_q[i] != 4'd0)) cd_d[i] = cd_q[i] - 4'd1;
    end
    if (pop) begin
      st_d[rd_ptr_q] = ST_EMPTY;
      rd_ptr_d       = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      st_d[wr_ptr_q]   = ST_WAIT;
      cd_d[wr_ptr_q]   = LAT_LOAD;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: reset discards every outstanding entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= ST_EMPTY;
        cd_q[i] <= 4'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_q     <= st_d;
      cd_q     <= cd_d;
    end
  end

  // Payload storage: only meaningful while the matching entry is waiting.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/sram_like_responder.sv
// Sram-like slave memory model: accepts requests into an in-order response
// queue, commits writes at accept, and returns the pre-access word after a
// fixed latency. Misaligned requests are answered but never written.
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int MEM_AW   = 12,
  parameter int RESP_LAT = 2,
  parameter int DEPTH    = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        accept_en,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]       mem_q [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic [31:0]       rd_word;
  logic [31:0]       mem_wdata;
  logic [3:0]        be;
  logic              mis;
  logic              accept;
  logic              mem_we;
  logic [CNT_W-1:0]  q_count;
  logic [31:0]       q_head_data;
  logic              q_head_ready;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              unused_addr_hi;

  // Upper address bits alias onto the same words.
  assign unused_addr_hi = ^addr[31:MEM_AW+2];

  assign idx     = addr[MEM_AW+1:2];
  assign rd_word = mem_q[idx];
  assign be      = be_of(size, addr[1:0]);
  assign mis     = misaligned(size, addr[1:0]);

  // No bypass: a slot freed by this cycle's pop is not usable until next cycle.
  assign addr_ok = req & accept_en & ~rst & (q_count < CNT_W'(DEPTH));
  assign accept  = addr_ok;
  assign mem_we  = accept & wr & ~mis;

  // Merge enabled write lanes over the current word.
  always_comb begin
    mem_wdata = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_wdata[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Memory is never cleared by reset; writes land at the accept edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= mem_wdata;
  end

  resp_queue #(
    .DEPTH    (DEPTH),
    .DATA_W   (32),
    .RESP_LAT (RESP_LAT)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_data  (rd_word),
    .pop        (q_head_ready),
    .count      (q_count),
    .head_data  (q_head_data),
    .head_ready (q_head_ready)
  );

  // Response outputs: pulse on pop, rdata holds between pulses, err is sticky.
  always_comb begin
    data_ok_d = q_head_ready;
    rdata_d   = q_head_ready ? q_head_data : rdata_q;
    err_d     = err_q | (accept & mis);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: a vector table of single
// transactions plus hand sequences for back-to-back, back-pressure,
// queue-full throughput, misalignment and mid-flight reset.
module tb_sram_like_responder;
  import sram_like_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, wr, accept_en;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;

  logic        req4, wr4, accept_en4;
  logic [1:0]  size4;
  logic [31:0] addr4, wdata4;
  logic        addr_ok4, data_ok4, err4;
  logic [31:0] rdata4;

  sram_like_responder #(.MEM_AW(12), .RESP_LAT(2), .DEPTH(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .accept_en(accept_en), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err)
  );

  sram_like_responder #(.MEM_AW(12), .RESP_LAT(4), .DEPTH(2), .INIT_FILE("")) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .wr(wr4), .size(size4), .addr(addr4),
    .wdata(wdata4), .accept_en(accept_en4), .addr_ok(addr_ok4), .data_ok(data_ok4),
    .rdata(rdata4), .err(err4)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        chk;
    logic        exp_err;
  } vec_t;

  vec_t vt[12];

  // One isolated transaction on the RESP_LAT=2 instance.
  task automatic txn(input vec_t v, input string nm);
    req = 1'b1; wr = v.wr; size = v.size; addr = v.addr; wdata = v.wdata;
    #1;
    check1({nm, ".addr_ok"}, addr_ok, 1'b1);
    tick;
    req = 1'b0;
    check1({nm, ".early"}, data_ok, 1'b0);
    tick;
    check1({nm, ".T+1"}, data_ok, 1'b0);
    tick;
    check1({nm, ".data_ok"}, data_ok, 1'b1);
    check1({nm, ".err"}, err, v.exp_err);
    if (v.chk) check32({nm, ".rdata"}, rdata, v.exp_rdata);
    tick;
    check1({nm, ".once"}, data_ok, 1'b0);
    if (v.chk) check32({nm, ".hold"}, rdata, v.exp_rdata);
  endtask

  bit exp_ok  [13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  bit exp_dok [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    vt[0]  = '{1'b1, SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
    vt[1]  = '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
    vt[2]  = '{1'b1, SZ_WORD, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vt[3]  = '{1'b1, SZ_BYTE, 32'h0000_0013, 32'hAB00_0000, 32'h1122_3344, 1'b1, 1'b0};
    vt[4]  = '{1'b0, SZ_WORD, 32'h0000_0010, 32'h0,         32'hAB22_3344, 1'b1, 1'b0};
    vt[5]  = '{1'b1, SZ_WORD, 32'h0000_0014, 32'h0,         32'h0,         1'b0, 1'b0};
    vt[6]  = '{1'b1, SZ_HALF, 32'h0000_0016, 32'h5A5A_0000, 32'h0,         1'b1, 1'b0};
    vt[7]  = '{1'b0, SZ_WORD, 32'h0000_0014, 32'h0,         32'h5A5A_0000, 1'b1, 1'b0};
    vt[8]  = '{1'b1, SZ_BYTE, 32'h0000_0015, 32'h0000_C300, 32'h5A5A_0000, 1'b1, 1'b0};
    vt[9]  = '{1'b0, SZ_WORD, 32'h0000_4014, 32'h0,         32'h5A5A_C300, 1'b1, 1'b0};
    vt[10] = '{1'b1, SZ_WORD, 32'h0000_0020, 32'h0102_0304, 32'h0,         1'b0, 1'b0};
    vt[11] = '{1'b1, SZ_WORD, 32'h0000_0030, 32'h1122_3344, 32'h0,         1'b0, 1'b0};

    rst = 1'b1; req = 1'b0; wr = 1'b0; size = SZ_WORD; addr = '0; wdata = '0; accept_en = 1'b1;
    req4 = 1'b0; wr4 = 1'b0; size4 = SZ_WORD; addr4 = '0; wdata4 = '0; accept_en4 = 1'b1;

    // Reset state
    tick; tick;
    req = 1'b1;
    #1;
    check1("rst.addr_ok", addr_ok, 1'b0);
    check1("rst.data_ok", data_ok, 1'b0);
    check32("rst.rdata", rdata, 32'h0);
    check1("rst.err", err, 1'b0);
    req = 1'b0;
    rst = 1'b0;
    tick;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      txn(vt[i], $sformatf("vec%0d", i));
      tick;
    end

    // Write byte then read word back-to-back
    req = 1'b1; wr = 1'b1; size = SZ_BYTE; addr = 32'h33; wdata = 32'hAB00_0000;
    #1;
    check1("b2b.ok0", addr_ok, 1'b1);
    tick;
    wr = 1'b0; size = SZ_WORD; addr = 32'h30;
    #1;
    check1("b2b.ok1", addr_ok, 1'b1);
    tick;
    req = 1'b0;
    check1("b2b.T+1", data_ok, 1'b0);
    tick;
    check1("b2b.dok0", data_ok, 1'b1);
    check32("b2b.rdata0", rdata, 32'h1122_3344);
    tick;
    check1("b2b.dok1", data_ok, 1'b1);
    check32("b2b.rdata1", rdata, 32'hAB22_3344);
    tick;
    check1("b2b.end", data_ok, 1'b0);

    // Back-pressure
    accept_en = 1'b0; req = 1'b1; wr = 1'b0; size = SZ_WORD; addr = 32'h30;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1($sformatf("bp.ok%0d", i), addr_ok, 1'b0);
      tick;
      check1($sformatf("bp.dok%0d", i), data_ok, 1'b0);
    end
    accept_en = 1'b1;
    #1;
    check1("bp.release", addr_ok, 1'b1);
    tick;
    req = 1'b0;
    tick;
    check1("bp.T+1", data_ok, 1'b0);
    tick;
    check1("bp.dok", data_ok, 1'b1);
    check32("bp.rdata", rdata, 32'hAB22_3344);
    tick;

    // Queue-full throughput on RESP_LAT=4, DEPTH=2
    for (int k = 0; k < 4; k++) begin
      req4 = 1'b1; wr4 = 1'b1; size4 = SZ_WORD; addr4 = 32'(4 * k); wdata4 = 32'hA0 + 32'(k);
      tick;
      req4 = 1'b0;
      repeat (5) tick;
    end
    begin
      int acc;
      int got;
      acc = 0;
      got = 0;
      wr4 = 1'b0;
      for (int c = 0; c < 13; c++) begin
        req4  = (acc < 4);
        addr4 = 32'(4 * acc);
        #1;
        check1($sformatf("thr.ok%0d", c), addr_ok4, exp_ok[c]);
        check1($sformatf("thr.dok%0d", c), data_ok4, exp_dok[c]);
        if (exp_dok[c]) begin
          check32($sformatf("thr.rdata%0d", got), rdata4, 32'hA0 + 32'(got));
          got++;
        end
        if (exp_ok[c]) acc++;
        tick;
      end
      req4 = 1'b0;
    end

    // Misaligned half write: answered, not written, err sticky
    req = 1'b1; wr = 1'b1; size = SZ_HALF; addr = 32'h21; wdata = 32'hFFFF_FFFF;
    #1;
    check1("mis.addr_ok", addr_ok, 1'b1);
    tick;
    req = 1'b0;
    check1("mis.err", err, 1'b1);
    tick;
    check1("mis.T+1", data_ok, 1'b0);
    tick;
    check1("mis.dok", data_ok, 1'b1);
    check32("mis.rdata", rdata, 32'h0102_0304);
    tick;
    check1("mis.once", data_ok, 1'b0);
    txn('{1'b0, SZ_WORD, 32'h20, 32'h0, 32'h0102_0304, 1'b1, 1'b1}, "mis.readback");
    tick;

    // Reset with two transactions outstanding
    req = 1'b1; wr = 1'b1; size = SZ_WORD; addr = 32'h40; wdata = 32'h0BAD_F00D;
    tick;
    wr = 1'b0; addr = 32'h30;
    #1;
    check1("mrst.ok1", addr_ok, 1'b1);
    tick;
    req = 1'b0;
    rst = 1'b1;
    #1;
    check1("mrst.data_ok", data_ok, 1'b0);
    check1("mrst.err", err, 1'b0);
    check32("mrst.rdata", rdata, 32'h0);
    req = 1'b1;
    #1;
    check1("mrst.addr_ok", addr_ok, 1'b0);
    req = 1'b0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check1($sformatf("mrst.quiet%0d", i), data_ok, 1'b0);
    end
    txn('{1'b0, SZ_WORD, 32'h40, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0}, "mrst.readback");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
